// File: rtl/noc_switch_alloc_if.sv
// Allocator-side bundle: input FIFO status and route in,
// FIFO read enables and crossbar selects out.
interface noc_switch_alloc_if #(
  parameter int NPORTS = 5
);
  logic [NPORTS-1:0]        in_valid;
  logic [NPORTS*NPORTS-1:0] in_sel;
  logic [NPORTS-1:0]        in_tail;
  logic [NPORTS-1:0]        in_drop;
  logic [NPORTS-1:0]        out_ok;
  logic                     nolocal_rd;
  logic [NPORTS-1:0]        in_rd;
  logic [NPORTS*NPORTS-1:0] out_gnt;
  logic [NPORTS-1:0]        out_fwd;
  logic [NPORTS-1:0]        out_locked;
  logic                     err_sel;

  modport master (
    output in_valid, in_sel, in_tail,
    output in_drop, out_ok, nolocal_rd,
    input  in_rd, out_gnt, out_fwd,
    input  out_locked, err_sel
  );

  modport slave (
    input  in_valid, in_sel, in_tail,
    input  in_drop, out_ok, nolocal_rd,
    output in_rd, out_gnt, out_fwd,
    output out_locked, err_sel
  );
endinterface

// File: rtl/noc_switch_alloc.sv
// Per-switch wormhole allocator: one lock and one
// round-robin pointer per output, zero-latency grants.
module noc_switch_alloc #(
  parameter int NPORTS     = 5,
  parameter int LOCAL_PORT = 0
) (
  input logic               clk,
  input logic               rst,
  noc_switch_alloc_if.slave bus
);
  localparam int N  = NPORTS;
  localparam int PW = $clog2(NPORTS);

  typedef enum logic {IDLE, LOCKED} ost_t;
  typedef logic [PW-1:0] idx_t;

  ost_t st_q  [N];
  ost_t st_d  [N];
  idx_t own_q [N];
  idx_t own_d [N];
  idx_t ptr_q [N];
  idx_t ptr_d [N];
  logic err_q;
  logic err_d;

  logic [N-1:0]   sel_ok;
  logic [N-1:0]   kill;
  logic [N-1:0]   req;
  logic [N-1:0]   elig [N];
  logic [N-1:0]   gnt  [N];
  idx_t           win  [N];
  logic [N-1:0]   win_v;
  logic [N-1:0]   fwd;
  logic [N-1:0]   tail_w;
  logic [N-1:0]   rd;
  logic [N-1:0]   locked;
  logic [N*N-1:0] gnt_flat;

  function automatic logic onehot(
    input logic [N-1:0] s
  );
    return (s != '0) &&
           ((s & (s - N'(1))) == '0);
  endfunction

  // kill: the flit leaves the FIFO without
  // crossing the switch (drop or local flush)
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sel_ok[i] = onehot(bus.in_sel[i*N +: N]);
      kill[i] = bus.in_valid[i] &
        (bus.in_drop[i] |
         ((i == LOCAL_PORT) & ~bus.nolocal_rd));
      req[i] = bus.in_valid[i] & sel_ok[i] &
        ~bus.in_drop[i] &
        ((i != LOCAL_PORT) | bus.nolocal_rd);
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        elig[j][i] = req[i] & bus.in_sel[i*N + j];
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int j = 0; j < N; j++) begin
      win_v[j] = 1'b0;
      win[j]   = '0;
      if (st_q[j] == LOCKED) begin
        win_v[j] = elig[j][own_q[j]];
        win[j]   = own_q[j];
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = int'(ptr_q[j]) + k;
          if (idx >= N) idx = idx - N;
          if (!win_v[j] &&
              elig[j][idx_t'(idx)]) begin
            win_v[j] = 1'b1;
            win[j]   = idx_t'(idx);
          end
        end
      end
      fwd[j]    = win_v[j] & bus.out_ok[j];
      tail_w[j] = bus.in_tail[win[j]];
      gnt[j]    = fwd[j] ? (N'(1) << win[j])
                         : '0;
    end
  end

  always_comb begin
    rd       = kill;
    gnt_flat = '0;
    locked   = '0;
    for (int j = 0; j < N; j++) begin
      rd = rd | gnt[j];
      gnt_flat[j*N +: N] = gnt[j];
      locked[j] = (st_q[j] == LOCKED);
    end
  end

  assign bus.in_rd      = rd;
  assign bus.out_gnt    = gnt_flat;
  assign bus.out_fwd    = fwd;
  assign bus.out_locked = locked;
  assign bus.err_sel    = err_q;

  // a dropped tail on the owner frees the
  // output without moving the pointer
  always_comb begin
    for (int j = 0; j < N; j++) begin
      st_d[j]  = st_q[j];
      own_d[j] = own_q[j];
      ptr_d[j] = ptr_q[j];
      if (fwd[j]) begin
        if (tail_w[j]) begin
          st_d[j]  = IDLE;
          ptr_d[j] = (win[j] == idx_t'(N-1))
                   ? '0 : win[j] + idx_t'(1);
        end else begin
          st_d[j]  = LOCKED;
          own_d[j] = win[j];
        end
      end else if (st_q[j] == LOCKED &&
                   kill[own_q[j]] &&
                   bus.in_tail[own_q[j]]) begin
        st_d[j] = IDLE;
      end
    end
    err_d = err_q | (|(bus.in_valid & ~sel_ok));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        st_q[j]  <= IDLE;
        own_q[j] <= '0;
        ptr_q[j] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int j = 0; j < N; j++) begin
        st_q[j]  <= st_d[j];
        own_q[j] <= own_d[j];
        ptr_q[j] <= ptr_d[j];
      end
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed and random checks of the switch allocator
// against a packet-level reference model.
module tb_noc_switch_alloc;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_switch_alloc_if #(.NPORTS(N)) bus ();

  noc_switch_alloc #(
    .NPORTS(N),
    .LOCAL_PORT(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int own [N];
  int ptr [N];
  bit err_m;
  int win [N];
  bit fwd_m [N];
  bit disc [N];

  logic [N-1:0]   e_rd, e_fwd, e_lock;
  logic [N*N-1:0] e_gnt;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit bad_sel(int i);
    return $countones(bus.in_sel[i*N +: N]) != 1;
  endfunction

  function automatic bit wants(int i, int j);
    return bus.in_valid[i] && !bad_sel(i) &&
      bus.in_sel[i*N + j] && !bus.in_drop[i] &&
      !(i == 0 && !bus.nolocal_rd);
  endfunction

  task automatic model_eval();
    e_rd = '0; e_gnt = '0;
    e_fwd = '0; e_lock = '0;
    for (int i = 0; i < N; i++) begin
      disc[i] = bus.in_valid[i] &&
        (bus.in_drop[i] ||
         (i == 0 && !bus.nolocal_rd));
      if (disc[i]) e_rd[i] = 1'b1;
    end
    for (int j = 0; j < N; j++) begin
      win[j] = -1;
      if (own[j] >= 0) begin
        if (wants(own[j], j)) win[j] = own[j];
      end else begin
        for (int k = 0; k < N; k++) begin
          if (win[j] < 0 && wants((ptr[j]+k)%N, j))
            win[j] = (ptr[j] + k) % N;
        end
      end
      fwd_m[j] = win[j] >= 0 && bus.out_ok[j];
      if (fwd_m[j]) begin
        e_fwd[j] = 1'b1;
        e_gnt[j*N + win[j]] = 1'b1;
        e_rd[win[j]] = 1'b1;
      end
      e_lock[j] = own[j] >= 0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        own[j] = -1;
        ptr[j] = 0;
      end
      err_m = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (bus.in_valid[i] && bad_sel(i)) err_m = 1'b1;
    for (int j = 0; j < N; j++) begin
      if (fwd_m[j]) begin
        if (bus.in_tail[win[j]]) begin
          own[j] = -1;
          ptr[j] = (win[j] + 1) % N;
        end else begin
          own[j] = win[j];
        end
      end else if (own[j] >= 0 && disc[own[j]] &&
                   bus.in_tail[own[j]]) begin
        own[j] = -1;
      end
    end
  endtask

  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, "/rd"}, bus.in_rd, e_rd);
    chk({tag, "/gnt"}, bus.out_gnt, e_gnt);
    chk({tag, "/fwd"}, bus.out_fwd, e_fwd);
    chk({tag, "/lock"}, bus.out_locked, e_lock);
    chk({tag, "/err"}, bus.err_sel, err_m);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid   = '0;
    bus.in_sel     = '0;
    bus.in_tail    = '0;
    bus.in_drop    = '0;
    bus.out_ok     = '1;
    bus.nolocal_rd = 1'b1;
  endtask

  task automatic set_in(int i, int j, bit t);
    bus.in_valid[i]       = 1'b1;
    bus.in_sel[i*N +: N]  = N'(1) << j;
    bus.in_tail[i]        = t;
  endtask

  initial begin
    idle();
    for (int j = 0; j < N; j++) begin
      own[j] = -1;
      ptr[j] = 0;
    end
    err_m = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset/lock", bus.out_locked, 5'b00000);
    chk("reset/err", bus.err_sel, 1'b0);
    chk("reset/rd", bus.in_rd, 5'b00000);
    step("reset");

    set_in(0, 2, 1'b1);
    #1;
    chk("t1/rd", bus.in_rd, 5'b00001);
    chk("t1/gnt2", bus.out_gnt[14:10], 5'b00001);
    chk("t1/fwd", bus.out_fwd, 5'b00100);
    chk("t1/lock", bus.out_locked, 5'b00000);
    step("t1");
    idle();

    set_in(1, 4, 1'b0);
    set_in(3, 4, 1'b0);
    #1;
    chk("t2/head", bus.in_rd, 5'b00010);
    step("t2a");
    bus.out_ok[4] = 1'b0;
    #1;
    chk("t3/rd", bus.in_rd, 5'b00000);
    chk("t3/fwd", bus.out_fwd[4], 1'b0);
    chk("t3/lock", bus.out_locked[4], 1'b1);
    step("t3a");
    step("t3b");
    bus.out_ok[4] = 1'b1;
    #1;
    chk("t3/resume", bus.in_rd, 5'b00010);
    step("t2b");
    bus.in_tail[1] = 1'b1;
    #1;
    chk("t2/tail", bus.in_rd, 5'b00010);
    step("t2c");
    bus.in_tail[1] = 1'b0;
    #1;
    chk("t2/rr", bus.in_rd, 5'b01000);
    step("t2d");
    idle();
    set_in(3, 4, 1'b1);
    step("t2e");
    idle();

    set_in(2, 1, 1'b0);
    step("t4a");
    bus.in_tail[2] = 1'b1;
    bus.in_drop[2] = 1'b1;
    #1;
    chk("t4/rd", bus.in_rd, 5'b00100);
    chk("t4/fwd", bus.out_fwd, 5'b00000);
    step("t4b");
    idle();
    #1;
    chk("t4/unlock", bus.out_locked[1], 1'b0);
    step("t4c");

    bus.in_valid[3] = 1'b1;
    bus.in_sel[15 +: 5] = 5'b00110;
    #1;
    chk("t5/rd", bus.in_rd, 5'b00000);
    chk("t5/fwd", bus.out_fwd, 5'b00000);
    step("t5a");
    idle();
    #1;
    chk("t5/err", bus.err_sel, 1'b1);
    step("t5b");
    step("t5c");

    bus.nolocal_rd = 1'b0;
    set_in(0, 3, 1'b0);
    #1;
    chk("t6/rd", bus.in_rd, 5'b00001);
    chk("t6/fwd", bus.out_fwd[3], 1'b0);
    step("t6a");
    bus.nolocal_rd = 1'b1;
    step("t6b");
    idle();
    #1;
    chk("t6/lock", bus.out_locked[3], 1'b1);
    rst = 1'b1;
    step("t6c");
    rst = 1'b0;
    #1;
    chk("t6/rstlk", bus.out_locked, 5'b00000);
    chk("t6/rsterr", bus.err_sel, 1'b0);
    step("t6d");

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.nolocal_rd = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        bus.in_valid[i] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 199) == 0)
          bus.in_sel[i*N +: N] = N'($urandom);
        else
          bus.in_sel[i*N +: N] =
            N'(1) << $urandom_range(0, N-1);
        bus.in_tail[i] = ($urandom_range(0, 2) == 0);
        bus.in_drop[i] = ($urandom_range(0, 29) == 0);
        bus.out_ok[i]  = ($urandom_range(0, 4) != 0);
      end
      step("rnd");
    end
    rst = 1'b0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
